// File: rtl/i2c_port_arbiter_pkg.sv
// i2c_arb_pkg: shared types and constants for the I2C port arbiter.
// Holds the arbiter state encoding and the board I2C bus index list
// (also used by the SoC CSR map to fill i_port_sel).
package i2c_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GUARD   = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Board I2C bus indices
  localparam int unsigned PORT_CAP_SENSE = 0;
  localparam int unsigned PORT_LIGHT     = 1;
  localparam int unsigned PORT_RH_TEMP   = 2;
  localparam int unsigned PORT_PMONITOR  = 3;
  localparam int unsigned PORT_HDMI      = 4;

  localparam int unsigned NUM_BOARD_PORTS = 5;

endpackage

// File: rtl/i2c_port_arbiter_if.sv
// i2c_port_arbiter_if: I2C master-side and pad-side line bundle of the arbiter.
//   i_m_scl_oe/i_m_sda_oe  master pull-low enables
//   i_m_scl_o/i_m_sda_o    master outputs (unused, open-drain)
//   o_m_scl_i/o_m_sda_i    line state returned to the master
//   o_scl_oe/o_sda_oe      per-pad pull-low enables
//   o_scl_o/o_sda_o        per-pad outputs (tied 0)
//   i_scl_i/i_sda_i        per-pad synchronised line inputs
// Modport slave is the arbiter view; modport master is the surrounding SoC view.
interface i2c_port_arbiter_if
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NPORTS = NUM_BOARD_PORTS
);

  logic              i_m_scl_oe;
  logic              i_m_sda_oe;
  logic              i_m_scl_o;
  logic              i_m_sda_o;
  logic              o_m_scl_i;
  logic              o_m_sda_i;
  logic [NPORTS-1:0] o_scl_oe;
  logic [NPORTS-1:0] o_sda_oe;
  logic [NPORTS-1:0] o_scl_o;
  logic [NPORTS-1:0] o_sda_o;
  logic [NPORTS-1:0] i_scl_i;
  logic [NPORTS-1:0] i_sda_i;

  modport slave (
    input  i_m_scl_oe, i_m_sda_oe, i_m_scl_o, i_m_sda_o, i_scl_i, i_sda_i,
    output o_m_scl_i, o_m_sda_i, o_scl_oe, o_sda_oe, o_scl_o, o_sda_o
  );

  modport master (
    output i_m_scl_oe, i_m_sda_oe, i_m_scl_o, i_m_sda_o, i_scl_i, i_sda_i,
    input  o_m_scl_i, o_m_sda_i, o_scl_oe, o_sda_oe, o_scl_o, o_sda_o
  );

endinterface

// File: rtl/i2c_port_arbiter.sv
// i2c_port_arbiter: shares one I2C master core between NREQ requesters and
// steers it onto one of NPORTS board buses. Round-robin arbitration, an
// idle-bus guard before each grant, and a stall timeout that revokes a grant.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_req           level requests, held for a whole transaction
//   i_port_sel      packed per-requester target port, slice r = [r*PW +: PW]
//   o_gnt           registered one-hot grant
//   o_busy          registered, high whenever not idle
//   o_timeout       registered one-cycle pulse on a forced release
//   bus             master/pad line bundle (combinational routing)
module i2c_port_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned NPORTS      = NUM_BOARD_PORTS,
  parameter int unsigned GUARD_CYC   = 16,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic                                                   i_clk,
  input  logic                                                   i_rst_n,
  input  logic [NREQ-1:0]                                        i_req,
  input  logic [NREQ*((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0]    i_port_sel,
  output logic [NREQ-1:0]                                        o_gnt,
  output logic                                                   o_busy,
  output logic                                                   o_timeout,
  i2c_port_arbiter_if.slave                                      bus
);

  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam bit            TO_EN      = (TIMEOUT_CYC != 0);

  arb_state_e        state, state_n;
  logic [RW-1:0]     cur_req, cur_req_n;
  logic [PW-1:0]     cur_port, cur_port_n;
  logic [RW-1:0]     rr_ptr, rr_ptr_n;
  logic [NREQ-1:0]   mask, mask_n;
  logic [GW-1:0]     guard_cnt, guard_cnt_n;
  logic [TW-1:0]     to_cnt, to_cnt_n;
  logic              scl_prev;
  logic [NREQ-1:0]   gnt_n;
  logic              busy_n, timeout_n;

  logic [NREQ-1:0]   elig;
  logic              found;
  logic [RW-1:0]     win;
  logic [PW-1:0]     win_port;
  logic [31:0]       pick_idx;
  logic              sel_scl, sel_sda;
  logic              req_cur;

  // Open-drain: master data outputs carry no information
  logic unused_inputs;
  assign unused_inputs = bus.i_m_scl_o ^ bus.i_m_sda_o;

  assign req_cur     = i_req[cur_req];
  assign bus.o_scl_o = '0;
  assign bus.o_sda_o = '0;

  // Eligible = requesting, not masked after a timeout, and pointing at a real bus
  always_comb begin
    elig = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      elig[r] = i_req[r] & ~mask[r] & (32'(i_port_sel[r*PW +: PW]) < NPORTS);
    end
  end

  // Round-robin pick: first eligible requester at or after rr_ptr
  always_comb begin
    found    = 1'b0;
    win      = '0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pick_idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && elig[RW'(pick_idx)]) begin
        found = 1'b1;
        win   = RW'(pick_idx);
      end
    end
  end

  // Port of the winning requester
  always_comb begin
    win_port = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (RW'(r) == win) win_port = i_port_sel[r*PW +: PW];
    end
  end

  // Line state of the currently selected bus
  always_comb begin
    sel_scl = 1'b1;
    sel_sda = 1'b1;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (cur_port == PW'(p)) begin
        sel_scl = bus.i_scl_i[p];
        sel_sda = bus.i_sda_i[p];
      end
    end
  end

  // Bus routing: readback in GUARD/GRANT, pull-low drive only in GRANT
  always_comb begin
    bus.o_scl_oe  = '0;
    bus.o_sda_oe  = '0;
    bus.o_m_scl_i = 1'b1;
    bus.o_m_sda_i = 1'b1;
    if (state == ST_GUARD || state == ST_GRANT) begin
      bus.o_m_scl_i = sel_scl;
      bus.o_m_sda_i = sel_sda;
    end
    if (state == ST_GRANT) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (cur_port == PW'(p)) begin
          bus.o_scl_oe[p] = bus.i_m_scl_oe;
          bus.o_sda_oe[p] = bus.i_m_sda_oe;
        end
      end
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_n     = state;
    cur_req_n   = cur_req;
    cur_port_n  = cur_port;
    rr_ptr_n    = rr_ptr;
    guard_cnt_n = guard_cnt;
    to_cnt_n    = to_cnt;
    mask_n      = mask & i_req;
    timeout_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (found) begin
          cur_req_n   = win;
          cur_port_n  = win_port;
          rr_ptr_n    = RW'((32'(win) + 32'd1) % NREQ);
          guard_cnt_n = '0;
          state_n     = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (!req_cur) begin
          state_n = ST_RELEASE;
        end else if (sel_scl && sel_sda) begin
          if (guard_cnt == GUARD_LAST) begin
            to_cnt_n = '0;
            state_n  = ST_GRANT;
          end else begin
            guard_cnt_n = guard_cnt + GW'(1);
          end
        end else begin
          guard_cnt_n = '0;
        end
      end
      ST_GRANT: begin
        if (!req_cur) begin
          state_n = ST_RELEASE;
        end else if (sel_scl != scl_prev) begin
          to_cnt_n = '0;
        end else if (TO_EN && to_cnt == TO_LAST) begin
          timeout_n       = 1'b1;
          mask_n[cur_req] = 1'b1;
          state_n         = ST_RELEASE;
        end else if (to_cnt != '1) begin
          to_cnt_n = to_cnt + TW'(1);
        end
      end
      ST_RELEASE: begin
        state_n = ST_IDLE;
      end
    endcase

    gnt_n  = (state_n == ST_GRANT) ? (NREQ'(1'b1) << cur_req_n) : '0;
    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cur_req   <= '0;
      cur_port  <= '0;
      rr_ptr    <= '0;
      mask      <= '0;
      guard_cnt <= '0;
      to_cnt    <= '0;
      scl_prev  <= 1'b1;
      o_gnt     <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      cur_req   <= cur_req_n;
      cur_port  <= cur_port_n;
      rr_ptr    <= rr_ptr_n;
      mask      <= mask_n;
      guard_cnt <= guard_cnt_n;
      to_cnt    <= to_cnt_n;
      scl_prev  <= sel_scl;
      o_gnt     <= gnt_n;
      o_busy    <= busy_n;
      o_timeout <= timeout_n;
    end
  end

endmodule

// File: tb/tb_i2c_port_arbiter.sv
// tb_i2c_port_arbiter: self-checking bench for i2c_port_arbiter
// (2 requesters, 5 buses, 16-cycle guard, 100-cycle stall timeout).
module tb_i2c_port_arbiter;

  localparam int NREQ   = 2;
  localparam int NPORTS = 5;
  localparam int GUARD  = 16;
  localparam int TMO    = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [5:0] port_sel;
  logic [1:0] gnt;
  logic       busy;
  logic       tmo;

  int total = 0;
  int bad   = 0;

  i2c_port_arbiter_if #(.NPORTS(NPORTS)) bus ();

  i2c_port_arbiter #(
    .NREQ(NREQ), .NPORTS(NPORTS), .GUARD_CYC(GUARD), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_port_sel(port_sel),
    .o_gnt(gnt), .o_busy(busy), .o_timeout(tmo), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [1:0] req;
    logic [2:0] sel0;
    logic [2:0] sel1;
    logic       m_scl_oe;
    int         wait_n;
    logic [1:0] gnt;
    logic       busy;
    logic [4:0] scl_oe;
  } vec_t;

  vec_t vtab[$];

  function automatic vec_t mk(logic [1:0] r, logic [2:0] s0, logic [2:0] s1, logic moe,
                              int w, logic [1:0] g, logic b, logic [4:0] oe);
    vec_t v;
    v.req = r; v.sel0 = s0; v.sel1 = s1; v.m_scl_oe = moe;
    v.wait_n = w; v.gnt = g; v.busy = b; v.scl_oe = oe;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 waiting for a quiet bus, 2 owning the bus, 3 one-cycle handback
  int         ph, own, own_port, quiet_run, stall_run, turn;
  bit         last_scl;
  bit [1:0]   blocked;
  logic [1:0] e_gnt;
  bit         e_busy, e_tmo;

  function automatic int sel_of(int r);
    return int'(port_sel[r*3 +: 3]);
  endfunction

  task automatic model_reset();
    ph = 0; own = 0; own_port = 0; quiet_run = 0; stall_run = 0; turn = 0;
    last_scl = 1'b1; blocked = '0; e_gnt = '0; e_busy = 1'b0; e_tmo = 1'b0;
  endtask

  task automatic model_step();
    int nph;
    bit fired;
    bit cs, cd;
    nph   = ph;
    fired = 1'b0;
    cs    = bus.i_scl_i[own_port];
    cd    = bus.i_sda_i[own_port];
    case (ph)
      0: for (int k = 0; k < NREQ; k++) begin
           int r;
           r = (turn + k) % NREQ;
           if (nph == 0 && req[r] && !blocked[r] && sel_of(r) < NPORTS) begin
             own = r; own_port = sel_of(r); turn = (r + 1) % NREQ;
             quiet_run = 0; nph = 1;
           end
         end
      1: if (!req[own]) nph = 3;
         else if (cs && cd) begin
           if (quiet_run == GUARD - 1) begin nph = 2; stall_run = 0; end
           else quiet_run++;
         end else quiet_run = 0;
      2: if (!req[own]) nph = 3;
         else if (cs != last_scl) stall_run = 0;
         else if (stall_run == TMO - 1) begin fired = 1'b1; nph = 3; end
         else stall_run++;
      default: nph = 0;
    endcase
    for (int r = 0; r < NREQ; r++) if (!req[r]) blocked[r] = 1'b0;
    if (fired) blocked[own] = 1'b1;
    last_scl = cs;
    ph       = nph;
    e_gnt    = (ph == 2) ? 2'(1 << own) : 2'b00;
    e_busy   = (ph != 0);
    e_tmo    = fired;
  endtask

  task automatic model_compare(input int cyc);
    logic [4:0] x_scl_oe, x_sda_oe;
    logic x_ms, x_md;
    x_scl_oe = (ph == 2 && bus.i_m_scl_oe) ? 5'(1 << own_port) : 5'b0;
    x_sda_oe = (ph == 2 && bus.i_m_sda_oe) ? 5'(1 << own_port) : 5'b0;
    x_ms = (ph == 1 || ph == 2) ? bus.i_scl_i[own_port] : 1'b1;
    x_md = (ph == 1 || ph == 2) ? bus.i_sda_i[own_port] : 1'b1;
    check($sformatf("rnd%0d_gnt", cyc), gnt, e_gnt);
    check($sformatf("rnd%0d_busy", cyc), busy, e_busy);
    check($sformatf("rnd%0d_timeout", cyc), tmo, e_tmo);
    check($sformatf("rnd%0d_scl_oe", cyc), bus.o_scl_oe, x_scl_oe);
    check($sformatf("rnd%0d_sda_oe", cyc), bus.o_sda_oe, x_sda_oe);
    check($sformatf("rnd%0d_m_scl_i", cyc), bus.o_m_scl_i, x_ms);
    check($sformatf("rnd%0d_m_sda_i", cyc), bus.o_m_sda_i, x_md);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    int   seg_left;
    bit   quiet;

    rst_n = 1'b0; req = '0; port_sel = '0;
    bus.i_m_scl_oe = 1'b0; bus.i_m_sda_oe = 1'b0;
    bus.i_m_scl_o = 1'b0;  bus.i_m_sda_o = 1'b0;
    bus.i_scl_i = '1;      bus.i_sda_i = '1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_gnt", gnt, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_timeout", tmo, 1'b0);
    check("reset_scl_oe", bus.o_scl_oe, 5'b0);
    check("reset_m_scl_i", bus.o_m_scl_i, 1'b1);
    check("reset_scl_o", bus.o_scl_o, 5'b0);
    @(negedge clk) rst_n = 1'b1;

    // req, sel0, sel1, m_scl_oe, wait, exp gnt, busy, scl_oe
    vtab.push_back(mk(2'b00, 3'd2, 3'd4, 1'b1,  2, 2'b00, 1'b0, 5'b00000));
    vtab.push_back(mk(2'b01, 3'd2, 3'd4, 1'b1, 16, 2'b00, 1'b1, 5'b00000));
    vtab.push_back(mk(2'b01, 3'd2, 3'd4, 1'b1,  1, 2'b01, 1'b1, 5'b00100));
    vtab.push_back(mk(2'b11, 3'd2, 3'd4, 1'b1, 20, 2'b01, 1'b1, 5'b00100));
    vtab.push_back(mk(2'b10, 3'd2, 3'd4, 1'b1,  1, 2'b00, 1'b1, 5'b00000));
    vtab.push_back(mk(2'b10, 3'd2, 3'd4, 1'b1,  1, 2'b00, 1'b0, 5'b00000));
    vtab.push_back(mk(2'b10, 3'd2, 3'd4, 1'b1,  1, 2'b00, 1'b1, 5'b00000));
    vtab.push_back(mk(2'b10, 3'd2, 3'd4, 1'b1, 15, 2'b00, 1'b1, 5'b00000));
    vtab.push_back(mk(2'b10, 3'd2, 3'd4, 1'b1,  1, 2'b10, 1'b1, 5'b10000));
    vtab.push_back(mk(2'b00, 3'd2, 3'd4, 1'b1,  1, 2'b00, 1'b1, 5'b00000));
    vtab.push_back(mk(2'b00, 3'd2, 3'd4, 1'b1,  1, 2'b00, 1'b0, 5'b00000));
    vtab.push_back(mk(2'b01, 3'd7, 3'd4, 1'b1,  5, 2'b00, 1'b0, 5'b00000));
    vtab.push_back(mk(2'b01, 3'd7, 3'd4, 1'b1, 30, 2'b00, 1'b0, 5'b00000));
    vtab.push_back(mk(2'b01, 3'd0, 3'd4, 1'b0, 17, 2'b01, 1'b1, 5'b00000));
    vtab.push_back(mk(2'b01, 3'd0, 3'd4, 1'b1,  1, 2'b01, 1'b1, 5'b00001));
    vtab.push_back(mk(2'b00, 3'd0, 3'd4, 1'b1,  2, 2'b00, 1'b0, 5'b00000));

    for (int i = 0; i < vtab.size(); i++) begin
      v = vtab[i];
      @(negedge clk);
      req = v.req; port_sel = {v.sel1, v.sel0}; bus.i_m_scl_oe = v.m_scl_oe;
      repeat (v.wait_n) @(posedge clk);
      #1;
      check($sformatf("vec%0d_gnt", i), gnt, v.gnt);
      check($sformatf("vec%0d_busy", i), busy, v.busy);
      check($sformatf("vec%0d_scl_oe", i), bus.o_scl_oe, v.scl_oe);
      check($sformatf("vec%0d_timeout", i), tmo, 1'b0);
      check($sformatf("vec%0d_m_scl_i", i), bus.o_m_scl_i, 1'b1);
    end

    // Guard restart: SDA low mid-guard restarts the 16-cycle idle count
    @(negedge clk);
    req = 2'b01; port_sel = {3'd4, 3'd2}; bus.i_m_scl_oe = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("grd_busy", busy, 1'b1);
    check("grd_gnt_early", gnt, 2'b00);
    @(negedge clk) bus.i_sda_i[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("grd_m_sda_i_low", bus.o_m_sda_i, 1'b0);
    check("grd_gnt_low", gnt, 2'b00);
    @(negedge clk) bus.i_sda_i[2] = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("grd_gnt_15", gnt, 2'b00);
    @(posedge clk);
    #1;
    check("grd_gnt_16", gnt, 2'b01);

    // Stall timeout: frozen SCL for 100 cycles in GRANT
    repeat (99) @(posedge clk);
    #1;
    check("tmo_gnt_99", gnt, 2'b01);
    check("tmo_pulse_99", tmo, 1'b0);
    check("tmo_scl_oe_99", bus.o_scl_oe, 5'b00100);
    @(posedge clk);
    #1;
    check("tmo_pulse_100", tmo, 1'b1);
    check("tmo_gnt_100", gnt, 2'b00);
    check("tmo_scl_oe_100", bus.o_scl_oe, 5'b00000);
    @(posedge clk);
    #1;
    check("tmo_pulse_101", tmo, 1'b0);
    check("tmo_busy_101", busy, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("tmo_masked_gnt", gnt, 2'b00);
    check("tmo_masked_busy", busy, 1'b0);
    @(negedge clk) req = 2'b00;
    @(posedge clk);
    @(negedge clk) req = 2'b01;
    repeat (16) @(posedge clk);
    #1;
    check("tmo_regrant_16", gnt, 2'b00);
    @(posedge clk);
    #1;
    check("tmo_regrant_17", gnt, 2'b01);

    // Async reset mid-GRANT: oe drop and master readback go to 1 with no clock edge
    @(negedge clk);
    #1;
    check("rst_pre_scl_oe", bus.o_scl_oe, 5'b00100);
    bus.i_scl_i[2] = 1'b0;
    #1;
    check("rst_pre_m_scl_i", bus.o_m_scl_i, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_scl_oe", bus.o_scl_oe, 5'b00000);
    check("rst_m_scl_i", bus.o_m_scl_i, 1'b1);
    check("rst_m_sda_i", bus.o_m_sda_i, 1'b1);
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", tmo, 1'b0);
    bus.i_scl_i = '1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the reference model
    seg_left = 0;
    quiet    = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (seg_left == 0) begin
        quiet    = ($urandom_range(0, 2) != 0);
        seg_left = $urandom_range(30, 250);
      end
      seg_left--;
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 149) == 0) req[r] = ~req[r];
        if ($urandom_range(0, 49) == 0)
          port_sel[r*3 +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                             : 3'($urandom_range(0, 4));
      end
      if (quiet) begin
        bus.i_scl_i = '1;
        bus.i_sda_i = '1;
      end else begin
        for (int p = 0; p < NPORTS; p++) begin
          if ($urandom_range(0, 2) == 0) bus.i_scl_i[p] = ~bus.i_scl_i[p];
          bus.i_sda_i[p] = ($urandom_range(0, 3) != 0);
        end
      end
      bus.i_m_scl_oe = 1'($urandom_range(0, 1));
      bus.i_m_sda_oe = 1'($urandom_range(0, 1));
      #1;
      model_compare(cyc);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
